// File: rtl/gf_det3_seq_if.sv
// Handshake and data bundle for the sequential GF(2^8) 3x3 determinant engine.
//   master: drives the matrix (d1..d9, in_valid) and out_ready; sees results.
//   slave : the engine; drives in_ready, out_valid, det, singular, busy.
// d1..d9 are the matrix elements in row-major order (row 1 = d1 d2 d3).
interface gf_det3_seq_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] d1, d2, d3, d4, d5, d6, d7, d8, d9;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] det;
  logic         singular;
  logic         busy;

  modport master (
    output in_valid, d1, d2, d3, d4, d5, d6, d7, d8, d9, out_ready,
    input  in_ready, out_valid, det, singular, busy
  );

  modport slave (
    input  in_valid, d1, d2, d3, d4, d5, d6, d7, d8, d9, out_ready,
    output in_ready, out_valid, det, singular, busy
  );
endinterface

// File: rtl/gf_det3_seq.sv
// gf_mul8: combinational GF(2^8) multiplier, polynomial x^8+x^4+x^3+x^2+1.
//   a, b : operands
//   p    : product
//
// gf_det3_seq: 3x3 determinant over GF(2^8) using one shared multiplier,
// nine multiply steps per matrix.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of gf_det3_seq_if (matrix in, det/singular out,
//                valid/ready on both sides, busy while computing)
module gf_mul8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] a_sh;
  logic [7:0] acc;

  always_comb begin
    // NOTE: combinational temporaries use blocking '=' so each loop pass sees
    // the previous pass's value; clocked state always uses '<='.
    a_sh = a;
    acc  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ a_sh;
      // Multiply a_sh by x, folding the x^8 term back in as 0x1D.
      a_sh = {a_sh[6:0], 1'b0} ^ (a_sh[7] ? 8'h1D : 8'h00);
    end
    p = acc;
  end
endmodule

module gf_det3_seq #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  gf_det3_seq_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   step;
  logic [W-1:0] op [9];    // op[0] = d1 ... op[8] = d9
  logic [W-1:0] cof;       // running 2x2 minor
  logic [W-1:0] acc;       // running determinant
  logic [W-1:0] det_q;
  logic         singular_q;
  logic         out_valid_q;
  logic         in_ready_q;
  logic         busy_q;

  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [W-1:0] prod;
  logic [W-1:0] acc_final;

  // Operand mux: two steps build a minor in cof, the third folds
  // (row-1 element * minor) into acc. Characteristic 2, so no signs.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a
    // latch is inferred for the unlisted step values.
    mul_a = '0;
    mul_b = '0;
    unique case (step)
      4'd0: begin mul_a = op[4]; mul_b = op[8]; end  // d5*d9
      4'd1: begin mul_a = op[5]; mul_b = op[7]; end  // d6*d8
      4'd2: begin mul_a = op[0]; mul_b = cof;   end  // d1*cof
      4'd3: begin mul_a = op[3]; mul_b = op[8]; end  // d4*d9
      4'd4: begin mul_a = op[5]; mul_b = op[6]; end  // d6*d7
      4'd5: begin mul_a = op[1]; mul_b = cof;   end  // d2*cof
      4'd6: begin mul_a = op[3]; mul_b = op[7]; end  // d4*d8
      4'd7: begin mul_a = op[4]; mul_b = op[6]; end  // d5*d7
      4'd8: begin mul_a = op[2]; mul_b = cof;   end  // d3*cof
      default: ;
    endcase
  end

  gf_mul8 u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  assign acc_final = acc ^ prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= 4'd0;
      // NOTE: the operand bank is small and must come up at 0x00, so it sits
      // in the async reset like every other register here.
      for (int i = 0; i < 9; i++) op[i] <= '0;
      cof         <= '0;
      acc         <= '0;
      det_q       <= '0;
      singular_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op[0]      <= bus.d1;
            op[1]      <= bus.d2;
            op[2]      <= bus.d3;
            op[3]      <= bus.d4;
            op[4]      <= bus.d5;
            op[5]      <= bus.d6;
            op[6]      <= bus.d7;
            op[7]      <= bus.d8;
            op[8]      <= bus.d9;
            cof        <= '0;
            acc        <= '0;
            step       <= 4'd0;
            state      <= BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        BUSY: begin
          step <= step + 4'd1;
          unique case (step)
            4'd0, 4'd3, 4'd6: cof <= prod;
            4'd1, 4'd4, 4'd7: cof <= cof ^ prod;
            4'd2, 4'd5:       acc <= acc_final;
            4'd8: begin
              acc         <= acc_final;
              det_q       <= acc_final;
              singular_q  <= (acc_final == '0);
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
              state       <= DONE;
            end
            default: begin
              // Unreachable step values recover to IDLE without a result.
              step       <= 4'd0;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b1;
              state      <= IDLE;
            end
          endcase
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            step        <= 4'd0;
            state       <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          step        <= 4'd0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.det       = det_q;
  assign bus.singular  = singular_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_gf_det3_seq.sv
// Testbench for gf_det3_seq: directed matrices, backpressure, mid-operation
// reset and a random regression against a log/antilog-table GF(2^8) model.
module tb_gf_det3_seq;
  typedef logic [7:0] mat_t [9];

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] gf_exp [256];
  int         gf_log [256];

  gf_det3_seq_if bus ();

  gf_det3_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tables over generator 0x02, which is primitive for 0x11D.
  task automatic build_tables();
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      gf_exp[i] = v[7:0];
      gf_log[v] = i;
      v = v * 2;
      if (v >= 256) v = v ^ 'h11D;
    end
    gf_exp[255] = gf_exp[0];
    gf_log[0]   = 0;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return gf_exp[(gf_log[a] + gf_log[b]) % 255];
  endfunction

  // Cofactor expansion along row 1; subtraction equals addition (XOR).
  function automatic logic [7:0] ref_det(input mat_t m);
    logic [7:0] m1, m2, m3;
    m1 = gmul(m[4], m[8]) ^ gmul(m[5], m[7]);
    m2 = gmul(m[3], m[8]) ^ gmul(m[5], m[6]);
    m3 = gmul(m[3], m[7]) ^ gmul(m[4], m[6]);
    return gmul(m[0], m1) ^ gmul(m[1], m2) ^ gmul(m[2], m3);
  endfunction

  task automatic set_d(input mat_t m);
    bus.d1 = m[0]; bus.d2 = m[1]; bus.d3 = m[2];
    bus.d4 = m[3]; bus.d5 = m[4]; bus.d6 = m[5];
    bus.d7 = m[6]; bus.d8 = m[7]; bus.d9 = m[8];
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < 9; i++) m[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    return m;
  endfunction

  // Waits up to 50 cycles for in_ready at a falling edge.
  task automatic wait_ready(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) check({tag, " in_ready timeout"}, 0, 1);
  endtask

  // Sends one matrix, checks latency and result, holds out_ready low for
  // 'hold' cycles while pushing ignored traffic, then accepts the result.
  task automatic do_matrix(input mat_t m, input string tag, input int hold);
    logic [7:0] want;
    int         lat;
    bit         seen;
    want = ref_det(m);
    wait_ready(tag, seen);
    if (!seen) return;
    bus.in_valid = 1'b1;
    set_d(m);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    set_d(rand_mat());   // captured operands must not follow the pins
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      lat = k;
      if (k == 1) begin
        check({tag, " busy"}, 32'(bus.busy), 1);
        check({tag, " in_ready busy"}, 32'(bus.in_ready), 0);
      end
      if (bus.out_valid) seen = 1'b1;
    end
    // Negedge k follows edge T+k-1, so edges after accept = lat-1.
    check({tag, " latency"}, 32'(lat - 1), 9);
    if (!seen) return;
    check({tag, " det"}, 32'(bus.det), 32'(want));
    check({tag, " singular"}, 32'(bus.singular), 32'(want == 8'h00));
    check({tag, " busy done"}, 32'(bus.busy), 0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      set_d(rand_mat());
      @(negedge clk);
      check({tag, " hold det"}, 32'(bus.det), 32'(want));
      check({tag, " hold out_valid"}, 32'(bus.out_valid), 1);
      check({tag, " hold in_ready"}, 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " accepted out_valid"}, 32'(bus.out_valid), 0);
    check({tag, " accepted in_ready"}, 32'(bus.in_ready), 1);
    check({tag, " det kept"}, 32'(bus.det), 32'(want));
  endtask

  initial begin
    mat_t ident, diag, eq, upper, m;
    bit   ok;
    checks = 0;
    errors = 0;
    build_tables();

    ident = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    diag  = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
    eq    = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
    upper = '{8'h02, 8'h35, 8'h7A, 8'h00, 8'h02, 8'hC4, 8'h00, 8'h00, 8'h02};

    // Model sanity against hand-derived values.
    check("model diag", 32'(ref_det(diag)), 32'h1D);
    check("model upper", 32'(ref_det(upper)), 32'h08);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_d(ident);
    rst_n = 1'b0;
    #12;
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset det", 32'(bus.det), 0);
    check("reset singular", 32'(bus.singular), 0);
    check("reset busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 1);

    do_matrix(ident, "identity", 0);
    do_matrix(diag, "diag", 0);
    do_matrix(eq, "equal_rows", 1);
    do_matrix(upper, "upper", 2);
    do_matrix(upper, "backpressure", 20);
    do_matrix(diag, "after_bp", 0);

    // Reset while the step counter sits at 4.
    wait_ready("rst_mid", ok);
    if (ok) begin
      bus.in_valid = 1'b1;
      set_d(ident);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid out_valid", 32'(bus.out_valid), 0);
      check("rst_mid busy", 32'(bus.busy), 0);
      check("rst_mid det", 32'(bus.det), 0);
      check("rst_mid singular", 32'(bus.singular), 0);
      check("rst_mid in_ready", 32'(bus.in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("rst_mid no result", 32'(bus.out_valid), 0);
    end
    do_matrix(ident, "post_reset_ident", 0);

    for (int n = 0; n < 1000; n++) begin
      m = rand_mat();
      if (n % 8 == 7) begin
        m[6] = m[0]; m[7] = m[1]; m[8] = m[2];
      end
      do_matrix(m, $sformatf("rand%0d", n), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
